// File: rtl/pipe_adder_pkg.sv
// Shared defaults, segment-count helper and the stage record layout for pipe_adder.
// Nothing here is clocked; it only fixes widths and types.
package pipe_adder_pkg;

    localparam int DEF_WIDTH     = 32;
    localparam int DEF_SEG_WIDTH = 16;

    function automatic int calc_nseg(input int width, input int seg_width);
        return width / seg_width;
    endfunction

    // Full-width view of one pipeline stage at the default sizes
    typedef struct packed {
        logic                 vld;
        logic                 carry;
        logic [DEF_WIDTH-1:0] psum;
        logic [DEF_WIDTH-1:0] opa;
        logic [DEF_WIDTH-1:0] opb;
    } stage_t;

endpackage

// File: rtl/adder_seg.sv
// Combinational SEG_WIDTH-bit adder slice with carry in/out.
// Zero latency, no flow control.
module adder_seg #(
    parameter int SEG_WIDTH = 16
) (
    input  logic [SEG_WIDTH-1:0] a,
    input  logic [SEG_WIDTH-1:0] b,
    input  logic                 cin,
    output logic [SEG_WIDTH-1:0] sum,
    output logic                 cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG_WIDTH{1'b0}}, cin};

endmodule

// File: rtl/pipe_adder.sv
// Segmented pipelined adder, one SEG_WIDTH slice per stage; latency NSEG cycles, 1 op/cycle.
// Global stall on out_valid & ~out_ready freezes every stage; PIPE_ADDER_OVF_EN adds the ovf output.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int SEG_WIDTH = DEF_SEG_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef PIPE_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int NSEG = calc_nseg(WIDTH, SEG_WIDTH);
    localparam int S    = SEG_WIDTH;

    if ((WIDTH % SEG_WIDTH) != 0 || NSEG < 1) begin : g_cfg_err
        $error("pipe_adder: WIDTH must be a positive multiple of SEG_WIDTH");
    end

    logic stall;
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // Stage k keeps sum slices 0..k and only the operand slices not yet added.
    for (genvar k = 0; k < NSEG; k++) begin : g_stg
        localparam int REM = NSEG - 1 - k;

        logic                 vld;
        logic                 carry;
        logic [(k+1)*S-1:0]   psum;
        logic [(k+1)*S-1:0]   psum_nxt;
        logic [(REM+1)*S-1:0] src_a;
        logic [(REM+1)*S-1:0] src_b;
        logic                 src_vld;
        logic                 src_carry;
        logic [S-1:0]         seg_sum;
        logic                 seg_cout;

        if (k == 0) begin : g_head
            assign src_vld   = in_valid;
            assign src_carry = cin;
            assign src_a     = in1;
            assign src_b     = in2;
            assign psum_nxt  = seg_sum;
        end else begin : g_body
            assign src_vld   = g_stg[k-1].vld;
            assign src_carry = g_stg[k-1].carry;
            assign src_a     = g_stg[k-1].g_keep.opa;
            assign src_b     = g_stg[k-1].g_keep.opb;
            assign psum_nxt  = {seg_sum, g_stg[k-1].psum};
        end

        adder_seg #(
            .SEG_WIDTH(S)
        ) u_seg (
            .a    (src_a[S-1:0]),
            .b    (src_b[S-1:0]),
            .cin  (src_carry),
            .sum  (seg_sum),
            .cout (seg_cout)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                vld   <= 1'b0;
                carry <= 1'b0;
                psum  <= '0;
            end else if (!stall) begin
                vld   <= src_vld;
                carry <= seg_cout;
                psum  <= psum_nxt;
            end
        end

        if (REM > 0) begin : g_keep
            logic [REM*S-1:0] opa;
            logic [REM*S-1:0] opb;

            always_ff @(posedge clk) begin
                if (rst) begin
                    opa <= '0;
                    opb <= '0;
                end else if (!stall) begin
                    opa <= src_a[(REM+1)*S-1:S];
                    opb <= src_b[(REM+1)*S-1:S];
                end
            end
        end
    end

    assign out_valid = g_stg[NSEG-1].vld;
    assign sum       = g_stg[NSEG-1].psum;
    assign cout      = g_stg[NSEG-1].carry;

`ifdef PIPE_ADDER_OVF_EN
    // The last stage's operand slice carries the operand MSBs, so overflow is decided there.
    logic ovf_nxt;
    logic ovf_q;

    assign ovf_nxt = (g_stg[NSEG-1].src_a[S-1] == g_stg[NSEG-1].src_b[S-1]) &
                     (g_stg[NSEG-1].seg_sum[S-1] != g_stg[NSEG-1].src_a[S-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (!stall) begin
            ovf_q <= ovf_nxt;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule
